// File: rtl/robot_controller_if.sv
// Sensor, command, timer and motor-action signals between the robot controller and its surroundings.
// The controller connects through the slave modport; the environment drives through the master.
interface robot_controller_if;
  localparam int unsigned CMD_W   = 3;
  localparam int unsigned ACT_W   = 3;
  localparam int unsigned TIMER_W = 27;

  logic               sensor_l;
  logic               sensor_m;
  logic               sensor_r;
  logic [CMD_W-1:0]   c_in;
  logic               received_direction;
  logic [TIMER_W-1:0] controller_timer_in;
  logic               controller_timer_reset;
  logic [ACT_W-1:0]   output_action;
  logic               start_ultrasonic;

  modport master (
    output sensor_l, sensor_m, sensor_r, c_in, received_direction, controller_timer_in,
    input  controller_timer_reset, output_action, start_ultrasonic
  );

  modport slave (
    input  sensor_l, sensor_m, sensor_r, c_in, received_direction, controller_timer_in,
    output controller_timer_reset, output_action, start_ultrasonic
  );
endinterface

// File: rtl/robot_controller.sv
// Line-following robot controller: accepts one command while idle and runs the manoeuvre to completion.
// Outputs are decoded combinationally from the state, and from the sensors in the line-follow states.
module robot_controller #(
  parameter int unsigned BACK_TIME = 1_000_000
) (
  input logic              clk,
  input logic              reset,
  robot_controller_if.slave bus
);

  localparam int unsigned ACT_W = 3;

  localparam logic [ACT_W-1:0] ACT_STOP        = 3'b000;
  localparam logic [ACT_W-1:0] ACT_FORWARD     = 3'b001;
  localparam logic [ACT_W-1:0] ACT_GENTLE_LEFT = 3'b010;
  localparam logic [ACT_W-1:0] ACT_SHARP_LEFT  = 3'b011;
  localparam logic [ACT_W-1:0] ACT_GENTLE_RGT  = 3'b100;
  localparam logic [ACT_W-1:0] ACT_SHARP_RGT   = 3'b101;
  localparam logic [ACT_W-1:0] ACT_BACKWARD    = 3'b110;

  localparam logic [2:0] CMD_FORWARD  = 3'b001;
  localparam logic [2:0] CMD_RIGHT    = 3'b010;
  localparam logic [2:0] CMD_LEFT     = 3'b011;
  localparam logic [2:0] CMD_TURN180  = 3'b100;
  localparam logic [2:0] CMD_BACKWARD = 3'b101;

  typedef enum logic [3:0] {
    STAND_STILL,
    FWD_0, FWD_1, FWD_2, FWD_3,
    LEFT_0, LEFT_1,
    RIGHT_0, RIGHT_1,
    U_0, U_1, U_2, U_3,
    BACK
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [2:0]       w_sensors;
  logic [ACT_W-1:0] w_follow;
  logic             w_back_done;

  assign w_sensors   = {bus.sensor_l, bus.sensor_m, bus.sensor_r};
  assign w_back_done = 32'(bus.controller_timer_in) >= BACK_TIME;

  // Steer back toward the line; centred, crossing or lost all mean straight on.
  always_comb begin
    w_follow = ACT_FORWARD;
    case (w_sensors)
      3'b110:  w_follow = ACT_GENTLE_LEFT;
      3'b100:  w_follow = ACT_SHARP_LEFT;
      3'b011:  w_follow = ACT_GENTLE_RGT;
      3'b001:  w_follow = ACT_SHARP_RGT;
      default: w_follow = ACT_FORWARD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= STAND_STILL;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state               = r_state;
    bus.output_action          = ACT_STOP;
    bus.controller_timer_reset = 1'b1;
    bus.start_ultrasonic       = 1'b0;
    case (r_state)
      STAND_STILL: begin
        if (bus.received_direction) begin
          case (bus.c_in)
            CMD_FORWARD:  w_next_state = FWD_0;
            CMD_LEFT:     w_next_state = LEFT_0;
            CMD_RIGHT:    w_next_state = RIGHT_0;
            CMD_TURN180:  w_next_state = U_0;
            CMD_BACKWARD: w_next_state = BACK;
            default:      w_next_state = STAND_STILL;
          endcase
        end
      end
      FWD_0: begin
        bus.output_action    = w_follow;
        bus.start_ultrasonic = 1'b1;
        if (w_sensors == 3'b111) w_next_state = FWD_1;
      end
      // Drive straight over the crossing until it has passed.
      FWD_1: begin
        bus.output_action    = ACT_FORWARD;
        bus.start_ultrasonic = 1'b1;
        if (w_sensors != 3'b111) w_next_state = FWD_2;
      end
      FWD_2: begin
        bus.output_action    = w_follow;
        bus.start_ultrasonic = 1'b1;
        if (w_sensors == 3'b111) w_next_state = FWD_3;
      end
      FWD_3: begin
        bus.output_action    = ACT_STOP;
        bus.start_ultrasonic = 1'b1;
        w_next_state         = STAND_STILL;
      end
      // Turns pivot off the current line, then stop once the middle sensor reacquires a line.
      LEFT_0: begin
        bus.output_action = ACT_SHARP_LEFT;
        if (!bus.sensor_m) w_next_state = LEFT_1;
      end
      LEFT_1: begin
        bus.output_action = ACT_SHARP_LEFT;
        if (bus.sensor_m) w_next_state = STAND_STILL;
      end
      RIGHT_0: begin
        bus.output_action = ACT_SHARP_RGT;
        if (!bus.sensor_m) w_next_state = RIGHT_1;
      end
      RIGHT_1: begin
        bus.output_action = ACT_SHARP_RGT;
        if (bus.sensor_m) w_next_state = STAND_STILL;
      end
      // A U-turn sweeps past the crossing branch before landing on the opposite line.
      U_0: begin
        bus.output_action = ACT_SHARP_RGT;
        if (!bus.sensor_m) w_next_state = U_1;
      end
      U_1: begin
        bus.output_action = ACT_SHARP_RGT;
        if (bus.sensor_m) w_next_state = U_2;
      end
      U_2: begin
        bus.output_action = ACT_SHARP_RGT;
        if (!bus.sensor_m) w_next_state = U_3;
      end
      U_3: begin
        bus.output_action = ACT_SHARP_RGT;
        if (bus.sensor_m) w_next_state = STAND_STILL;
      end
      BACK: begin
        bus.output_action          = ACT_BACKWARD;
        bus.controller_timer_reset = 1'b0;
        if (w_back_done) w_next_state = STAND_STILL;
      end
      default: w_next_state = STAND_STILL;
    endcase
  end

endmodule

// File: tb/tb_robot_controller.sv
// Directed bench for robot_controller with a behavioural model of the external 27-bit timer.
module tb_robot_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic [26:0] r_timer = '0;
  int          checks = 0;
  int          errors = 0;

  robot_controller_if bus();

  robot_controller #(.BACK_TIME(100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // External timer: cleared while its reset request is high, otherwise free-running.
  always @(posedge clk) begin
    if (bus.controller_timer_reset) r_timer <= '0;
    else                            r_timer <= r_timer + 27'd1;
  end
  assign bus.controller_timer_in = r_timer;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sens(input logic [2:0] s);
    {bus.sensor_l, bus.sensor_m, bus.sensor_r} = s;
  endtask

  task automatic command(input logic [2:0] c, input logic [2:0] s);
    set_sens(s);
    bus.c_in = c;
    bus.received_direction = 1'b1;
    tick();
    bus.received_direction = 1'b0;
    bus.c_in = 3'b000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.received_direction = 1'b0;
    bus.c_in = 3'b000;
    set_sens(3'b000);
    repeat (10) tick();
    checks++; if (bus.output_action !== 3'b000) begin errors++; $display("FAIL reset_action got=%b exp=000", bus.output_action); end
    checks++; if (bus.controller_timer_reset !== 1'b1) begin errors++; $display("FAIL reset_timer_reset got=%b exp=1", bus.controller_timer_reset); end
    checks++; if (bus.start_ultrasonic !== 1'b0) begin errors++; $display("FAIL reset_ultrasonic got=%b exp=0", bus.start_ultrasonic); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_forward();
    logic [2:0] sens_tab [6] = '{3'b110, 3'b100, 3'b011, 3'b001, 3'b000, 3'b101};
    logic [2:0] act_tab  [6] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b001, 3'b001};
    command(3'b001, 3'b010);
    checks++; if (bus.start_ultrasonic !== 1'b1) begin errors++; $display("FAIL fwd0_ultrasonic got=%b exp=1", bus.start_ultrasonic); end
    checks++; if (bus.output_action !== 3'b001) begin errors++; $display("FAIL fwd0_action got=%b exp=001", bus.output_action); end
    for (int i = 0; i < 6; i++) begin
      set_sens(sens_tab[i]);
      #1;
      checks++; if (bus.output_action !== act_tab[i]) begin errors++; $display("FAIL follow_%b got=%b exp=%b", sens_tab[i], bus.output_action, act_tab[i]); end
      tick();
    end
    set_sens(3'b111);
    tick();
    set_sens(3'b110);
    #1;
    checks++; if (bus.output_action !== 3'b001) begin errors++; $display("FAIL fwd1_straight got=%b exp=001", bus.output_action); end
    tick();
    checks++; if (bus.output_action !== 3'b010) begin errors++; $display("FAIL fwd2_follow got=%b exp=010", bus.output_action); end
    set_sens(3'b111);
    tick();
    checks++; if (bus.output_action !== 3'b000 || bus.start_ultrasonic !== 1'b1) begin errors++; $display("FAIL fwd3 got=%b/%b exp=000/1", bus.output_action, bus.start_ultrasonic); end
    set_sens(3'b010);
    tick();
    checks++; if (bus.output_action !== 3'b000 || bus.start_ultrasonic !== 1'b0) begin errors++; $display("FAIL fwd_done got=%b/%b exp=000/0", bus.output_action, bus.start_ultrasonic); end
  endtask

  task automatic test_left();
    command(3'b011, 3'b010);
    checks++; if (bus.output_action !== 3'b011 || bus.start_ultrasonic !== 1'b0) begin errors++; $display("FAIL left0 got=%b/%b exp=011/0", bus.output_action, bus.start_ultrasonic); end
    tick();
    checks++; if (bus.output_action !== 3'b011) begin errors++; $display("FAIL left0_hold got=%b exp=011", bus.output_action); end
    set_sens(3'b000);
    tick();
    checks++; if (bus.output_action !== 3'b011) begin errors++; $display("FAIL left1 got=%b exp=011", bus.output_action); end
    command(3'b001, 3'b000);
    checks++; if (bus.output_action !== 3'b011 || bus.start_ultrasonic !== 1'b0) begin errors++; $display("FAIL left1_ignore_strobe got=%b/%b exp=011/0", bus.output_action, bus.start_ultrasonic); end
    set_sens(3'b010);
    tick();
    checks++; if (bus.output_action !== 3'b000) begin errors++; $display("FAIL left_done got=%b exp=000", bus.output_action); end
    tick();
    checks++; if (bus.output_action !== 3'b000 || bus.start_ultrasonic !== 1'b0) begin errors++; $display("FAIL left_no_queue got=%b/%b exp=000/0", bus.output_action, bus.start_ultrasonic); end
  endtask

  task automatic test_right();
    command(3'b010, 3'b111);
    checks++; if (bus.output_action !== 3'b101) begin errors++; $display("FAIL right0 got=%b exp=101", bus.output_action); end
    set_sens(3'b000);
    tick();
    checks++; if (bus.output_action !== 3'b101) begin errors++; $display("FAIL right1 got=%b exp=101", bus.output_action); end
    set_sens(3'b010);
    tick();
    checks++; if (bus.output_action !== 3'b000) begin errors++; $display("FAIL right_done got=%b exp=000", bus.output_action); end
  endtask

  task automatic test_uturn();
    logic [2:0] sens_tab [4] = '{3'b000, 3'b010, 3'b000, 3'b010};
    logic [2:0] act_tab  [4] = '{3'b101, 3'b101, 3'b101, 3'b000};
    command(3'b100, 3'b010);
    checks++; if (bus.output_action !== 3'b101) begin errors++; $display("FAIL u0 got=%b exp=101", bus.output_action); end
    for (int i = 0; i < 4; i++) begin
      set_sens(sens_tab[i]);
      tick();
      checks++; if (bus.output_action !== act_tab[i]) begin errors++; $display("FAIL uturn_step%0d got=%b exp=%b", i, bus.output_action, act_tab[i]); end
    end
  endtask

  task automatic test_back();
    int cnt;
    command(3'b101, 3'b010);
    checks++; if (bus.output_action !== 3'b110 || bus.controller_timer_reset !== 1'b0) begin errors++; $display("FAIL back_entry got=%b/%b exp=110/0", bus.output_action, bus.controller_timer_reset); end
    cnt = 1;
    while (bus.output_action === 3'b110 && cnt < 300) begin
      tick();
      if (bus.output_action === 3'b110) cnt++;
    end
    checks++; if (cnt != 101) begin errors++; $display("FAIL back_duration got=%0d exp=101", cnt); end
    checks++; if (bus.output_action !== 3'b000 || bus.controller_timer_reset !== 1'b1) begin errors++; $display("FAIL back_done got=%b/%b exp=000/1", bus.output_action, bus.controller_timer_reset); end
  endtask

  task automatic test_null_commands();
    logic [2:0] cmd_tab [3] = '{3'b000, 3'b110, 3'b111};
    for (int i = 0; i < 3; i++) begin
      command(cmd_tab[i], 3'b010);
      checks++; if (bus.output_action !== 3'b000 || bus.start_ultrasonic !== 1'b0 || bus.controller_timer_reset !== 1'b1) begin errors++; $display("FAIL null_cmd_%b got=%b/%b/%b exp=000/0/1", cmd_tab[i], bus.output_action, bus.start_ultrasonic, bus.controller_timer_reset); end
    end
  endtask

  task automatic test_reset_mid_fwd();
    command(3'b001, 3'b010);
    set_sens(3'b111);
    tick();
    set_sens(3'b010);
    tick();
    checks++; if (bus.start_ultrasonic !== 1'b1 || bus.output_action !== 3'b001) begin errors++; $display("FAIL fwd2_before_reset got=%b/%b exp=1/001", bus.start_ultrasonic, bus.output_action); end
    reset = 1'b1;
    command(3'b011, 3'b010);
    reset = 1'b0;
    checks++; if (bus.output_action !== 3'b000 || bus.start_ultrasonic !== 1'b0 || bus.controller_timer_reset !== 1'b1) begin errors++; $display("FAIL reset_mid_fwd got=%b/%b/%b exp=000/0/1", bus.output_action, bus.start_ultrasonic, bus.controller_timer_reset); end
    tick();
    checks++; if (bus.output_action !== 3'b000) begin errors++; $display("FAIL reset_cmd_dropped got=%b exp=000", bus.output_action); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_left();
    test_right();
    test_uturn();
    test_back();
    test_null_commands();
    test_reset_mid_fwd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog expired");
  end
endmodule
